mult_share_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one word-level taint-tracking sequential multiplier between NUM_REQ requesters. It accepts a request and clears the multiplier. It then issues a single start pulse and waits a fixed, operand-independent number of cycles. Finally it returns the product and its taint to the winning requester. It sits between the client blocks and the single multiplier instance, and it preserves constant-time behaviour end to end.

---
 rtl/mult_arb_pkg.sv | 8 +
 rtl/mult_rr_pick.sv | 27 ++
 rtl/mult_share_arb.sv | 122 ++++++++++++
 tb/tb_mult_share_arb.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg: shared FSM states, default latency and counter sizing for the multiplier arbiter
package mult_arb_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CLR, S_START, S_WAIT, S_DONE} state_e;
  localparam int LATENCY_DEFAULT = 20;
  function automatic int cnt_width(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction
endpackage

// File: rtl/mult_rr_pick.sv
// mult_rr_pick: combinational round-robin picker, first asserted request at or after ptr
module mult_rr_pick #(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IW-1:0]      idx_o
);
  logic [IW:0] s;
  // scan from the farthest slot down so the closest asserted slot to ptr wins
  always_comb begin
    grant_o = '0;
    idx_o = '0;
    s = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      s = {1'b0, ptr_i} + (IW+1)'(k);
      if (s >= (IW+1)'(NUM_REQ)) s = s - (IW+1)'(NUM_REQ);
      if (req_i[s[IW-1:0]]) begin
        grant_o = '0;
        grant_o[s[IW-1:0]] = 1'b1;
        idx_o = s[IW-1:0];
      end
    end
  end
endmodule

// File: rtl/mult_share_arb.sv
// mult_share_arb: round-robin sharing of one sequential multiplier with fixed, operand-independent latency
module mult_share_arb
  import mult_arb_pkg::*;
#(
  parameter int NUM_BITS = 7,
  parameter int NUM_REQ  = 4,
  parameter int LATENCY  = LATENCY_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*NUM_BITS-1:0] req_multiplier,
  input  logic [NUM_REQ*NUM_BITS-1:0] req_multiplicand,
  input  logic [NUM_REQ-1:0]       req_multiplier_t,
  input  logic [NUM_REQ-1:0]       req_multiplicand_t,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [2*NUM_BITS-1:0]    rsp_product,
  output logic                     rsp_product_t,
  output logic                     busy,
  output logic                     mul_rst,
  output logic                     mul_start,
  output logic                     mul_start_t,
  output logic [NUM_BITS-1:0]      mul_multiplier,
  output logic [NUM_BITS-1:0]      mul_multiplicand,
  output logic                     mul_multiplier_t,
  output logic                     mul_multiplicand_t,
  input  logic [2*NUM_BITS-1:0]    mul_product
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = cnt_width(LATENCY);
  localparam int PW = 2 * NUM_BITS;
  state_e state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, grant_q, grant_d, pick_idx;
  logic [NUM_REQ-1:0] pick_oh;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NUM_BITS-1:0] mult_q, mult_d, mcand_q, mcand_d;
  logic mult_t_q, mult_t_d, mcand_t_q, mcand_t_d;
  logic [PW-1:0] prod_q, prod_d;
  logic prod_t_q, prod_t_d;
  logic hs, cnt_zero;

  mult_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i(req_valid),
    .ptr_i(ptr_q),
    .grant_o(pick_oh),
    .idx_o(pick_idx)
  );

  assign hs = (state_q == S_IDLE) && |req_valid;
  assign cnt_zero = cnt_q == '0;

  // state and datapath registers; reset drops any transaction in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ptr_q <= '0;
      grant_q <= '0;
      cnt_q <= '0;
      mult_q <= '0;
      mcand_q <= '0;
      mult_t_q <= 1'b0;
      mcand_t_q <= 1'b0;
      prod_q <= '0;
      prod_t_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      grant_q <= grant_d;
      cnt_q <= cnt_d;
      mult_q <= mult_d;
      mcand_q <= mcand_d;
      mult_t_q <= mult_t_d;
      mcand_t_q <= mcand_t_d;
      prod_q <= prod_d;
      prod_t_q <= prod_t_d;
    end
  end

  // fixed path IDLE->CLR->START->WAIT(LATENCY)->DONE, never shortened by operand values
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  state_d = hs ? S_CLR : S_IDLE;
      S_CLR:   state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT:  state_d = cnt_zero ? S_DONE : S_WAIT;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // latch the winner on handshake, count down the wait, capture the product at zero
  always_comb begin
    grant_d = hs ? pick_idx : grant_q;
    mult_d = hs ? req_multiplier[pick_idx*NUM_BITS +: NUM_BITS] : mult_q;
    mcand_d = hs ? req_multiplicand[pick_idx*NUM_BITS +: NUM_BITS] : mcand_q;
    mult_t_d = hs ? req_multiplier_t[pick_idx] : mult_t_q;
    mcand_t_d = hs ? req_multiplicand_t[pick_idx] : mcand_t_q;
    ptr_d = (state_q != S_DONE) ? ptr_q : (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
    cnt_d = (state_q == S_START) ? CW'(LATENCY - 1) : (state_q == S_WAIT && !cnt_zero) ? cnt_q - 1'b1 : cnt_q;
    prod_d = (state_q == S_WAIT && cnt_zero) ? mul_product : prod_q;
    prod_t_d = (state_q == S_WAIT && cnt_zero) ? (mult_t_q | mcand_t_q) : prod_t_q;
  end

  // state-decoded control outputs; multiplier is held in reset while rst is low
  always_comb begin
    req_ready = (state_q == S_IDLE) ? pick_oh : '0;
    rsp_valid = (state_q == S_DONE) ? (NUM_REQ'(1) << grant_q) : '0;
    busy = state_q != S_IDLE;
    mul_rst = !rst || (state_q == S_CLR);
    mul_start = state_q == S_START;
    mul_start_t = 1'b0;
  end

  assign mul_multiplier = mult_q;
  assign mul_multiplicand = mcand_q;
  assign mul_multiplier_t = mult_t_q;
  assign mul_multiplicand_t = mcand_t_q;
  assign rsp_product = prod_q;
  assign rsp_product_t = prod_t_q;
endmodule

// File: tb/tb_mult_share_arb.sv
// tb_mult_share_arb: table vectors plus randomized rows against a cycle-timeline reference model
module tb_mult_share_arb;
  localparam int NB = 7;
  localparam int NR = 4;
  localparam int L = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NR-1:0] req_valid = '0;
  logic [NR-1:0] req_ready, rsp_valid;
  logic [NR-1:0] mt_i = '0;
  logic [NR-1:0] mct_i = '0;
  logic [NR*NB-1:0] req_multiplier = '0;
  logic [NR*NB-1:0] req_multiplicand = '0;
  logic [2*NB-1:0] rsp_product, mul_product;
  logic rsp_product_t, busy, mul_rst, mul_start, mul_start_t, mul_multiplier_t, mul_multiplicand_t;
  logic [NB-1:0] mul_multiplier, mul_multiplicand;
  logic [4:0] mcnt;

  always #5 clk = ~clk;

  mult_share_arb #(.NUM_BITS(NB), .NUM_REQ(NR), .LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_multiplier(req_multiplier), .req_multiplicand(req_multiplicand),
    .req_multiplier_t(mt_i), .req_multiplicand_t(mct_i),
    .rsp_valid(rsp_valid), .rsp_product(rsp_product), .rsp_product_t(rsp_product_t),
    .busy(busy), .mul_rst(mul_rst), .mul_start(mul_start), .mul_start_t(mul_start_t),
    .mul_multiplier(mul_multiplier), .mul_multiplicand(mul_multiplicand),
    .mul_multiplier_t(mul_multiplier_t), .mul_multiplicand_t(mul_multiplicand_t),
    .mul_product(mul_product)
  );

  // stand-in sequential multiplier: result appears 13 cycles after start, well inside LATENCY
  always_ff @(posedge clk) begin
    if (mul_rst) begin
      mcnt <= '0;
      mul_product <= '0;
    end else if (mul_start) mcnt <= 5'd12;
    else if (mcnt != 0) begin
      mcnt <= mcnt - 1'b1;
      if (mcnt == 1) mul_product <= 14'(mul_multiplier) * 14'(mul_multiplicand);
    end
  end

  typedef struct {
    int cnt[NR];
    int a[NR];
    int b[NR];
    logic [NR-1:0] ta, tb, late;
    int late_at, rst_at, n;
    int ord[5];
    int prod[5];
    logic [4:0] tnt;
  } vec_t;

  vec_t tv[6];
  int tests = 0, fails = 0, ptr_m = 0;
  int cnt_left[NR];
  logic [NB-1:0] a_op[NR], b_op[NR];
  logic ta[NR], tb[NR];
  logic [NR-1:0] late_mask;
  int late_at, rst_at;
  int sv_g[$], sv_p[$];
  logic sv_t[$];

  function automatic int pick(input logic [NR-1:0] v, input int p);
    for (int k = 0; k < NR; k++) if (v[(p + k) % NR]) return (p + k) % NR;
    return -1;
  endfunction

  function automatic int left();
    int s = 0;
    for (int i = 0; i < NR; i++) s += cnt_left[i];
    return s;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    req_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    ptr_m = 0;
  endtask

  task automatic load_vec(input vec_t v);
    for (int i = 0; i < NR; i++) begin
      cnt_left[i] = v.cnt[i];
      a_op[i] = NB'(v.a[i]);
      b_op[i] = NB'(v.b[i]);
      ta[i] = v.ta[i];
      tb[i] = v.tb[i];
    end
    late_mask = v.late;
    late_at = v.late_at;
    rst_at = v.rst_at;
  endtask

  task automatic run(input string tag);
    int fl_g, fl_a, drop_g, prev_done, w, cyc;
    logic pend_done, done, fin;
    logic [NR-1:0] er;
    fl_g = -1; fl_a = 0; drop_g = -1; prev_done = -1; pend_done = 0; fin = 0;
    sv_g.delete(); sv_p.delete(); sv_t.delete();
    for (cyc = 0; cyc < 500 && !fin; cyc++) begin
      @(negedge clk);
      if (cyc == 0)
        for (int i = 0; i < NR; i++) begin
          req_valid[i] = cnt_left[i] > 0 && !late_mask[i];
          req_multiplier[i*NB +: NB] = a_op[i];
          req_multiplicand[i*NB +: NB] = b_op[i];
          mt_i[i] = ta[i];
          mct_i[i] = tb[i];
        end
      if (cyc == late_at)
        for (int i = 0; i < NR; i++) if (late_mask[i] && cnt_left[i] > 0) req_valid[i] = 1'b1;
      if (drop_g >= 0) begin
        if (cnt_left[drop_g] == 0) req_valid[drop_g] = 1'b0;
        drop_g = -1;
      end
      rst = (cyc == rst_at) ? 1'b0 : 1'b1;
      #1;
      if (!rst) begin
        chk($sformatf("%s c%0d rst busy", tag, cyc), busy, 0);
        chk($sformatf("%s c%0d rst rsp_valid", tag, cyc), rsp_valid, 0);
        chk($sformatf("%s c%0d rst mul_rst", tag, cyc), mul_rst, 1);
        chk($sformatf("%s c%0d rst mul_start", tag, cyc), mul_start, 0);
        chk($sformatf("%s c%0d rst rsp_product", tag, cyc), rsp_product, 0);
        chk($sformatf("%s c%0d rst rsp_product_t", tag, cyc), rsp_product_t, 0);
        chk($sformatf("%s c%0d rst mul_multiplier", tag, cyc), mul_multiplier, 0);
        chk($sformatf("%s c%0d rst mul_multiplier_t", tag, cyc), mul_multiplier_t, 0);
        fl_g = -1; ptr_m = 0; prev_done = -1;
      end else begin
        done = fl_g >= 0 && cyc == fl_a + 3 + L;
        er = (fl_g < 0 && req_valid != 0) ? NR'(1 << pick(req_valid, ptr_m)) : '0;
        chk($sformatf("%s c%0d busy", tag, cyc), busy, fl_g >= 0);
        chk($sformatf("%s c%0d rsp_valid", tag, cyc), rsp_valid, done ? (1 << fl_g) : 0);
        chk($sformatf("%s c%0d mul_rst", tag, cyc), mul_rst, fl_g >= 0 && cyc == fl_a + 1);
        chk($sformatf("%s c%0d mul_start", tag, cyc), mul_start, fl_g >= 0 && cyc == fl_a + 2);
        chk($sformatf("%s c%0d mul_start_t", tag, cyc), mul_start_t, 0);
        chk($sformatf("%s c%0d req_ready", tag, cyc), req_ready, er);
        if (fl_g >= 0 && (cyc == fl_a + 1 || done)) begin
          chk($sformatf("%s c%0d mul_multiplier", tag, cyc), mul_multiplier, a_op[fl_g]);
          chk($sformatf("%s c%0d mul_multiplicand", tag, cyc), mul_multiplicand, b_op[fl_g]);
          chk($sformatf("%s c%0d mul_multiplier_t", tag, cyc), mul_multiplier_t, ta[fl_g]);
          chk($sformatf("%s c%0d mul_multiplicand_t", tag, cyc), mul_multiplicand_t, tb[fl_g]);
        end
        if (done) begin
          chk($sformatf("%s c%0d rsp_product", tag, cyc), rsp_product, 32'(a_op[fl_g]) * 32'(b_op[fl_g]));
          chk($sformatf("%s c%0d rsp_product_t", tag, cyc), rsp_product_t, ta[fl_g] | tb[fl_g]);
          sv_g.push_back(fl_g);
          sv_p.push_back(int'(rsp_product));
          sv_t.push_back(rsp_product_t);
          ptr_m = (fl_g + 1) % NR;
          prev_done = cyc;
          pend_done = req_valid != 0;
          fl_g = -1;
        end else if (er != 0) begin
          w = pick(req_valid, ptr_m);
          if (prev_done >= 0 && pend_done) chk($sformatf("%s c%0d back-to-back accept", tag, cyc), cyc, prev_done + 1);
          fl_g = w; fl_a = cyc; cnt_left[w]--; drop_g = w; prev_done = -1;
        end
      end
      fin = rst && fl_g < 0 && cyc >= late_at && cyc >= rst_at && left() == 0;
    end
    chk($sformatf("%s completion within budget", tag), fin, 1);
  endtask

  initial begin
    tv[0] = '{'{1,0,0,0}, '{15,0,0,0}, '{15,0,0,0}, 4'b0000, 4'b0000, 4'b0000, -1, -1, 1,
              '{0,0,0,0,0}, '{225,0,0,0,0}, 5'b00000};
    tv[1] = '{'{1,1,1,1}, '{92,42,1,0}, '{75,78,2,12}, 4'b0000, 4'b0000, 4'b0000, -1, -1, 4,
              '{0,1,2,3,0}, '{6900,3276,2,0,0}, 5'b00000};
    tv[2] = '{'{0,0,1,0}, '{0,0,0,0}, '{0,0,0,0}, 4'b0100, 4'b0000, 4'b0000, -1, -1, 1,
              '{2,0,0,0,0}, '{0,0,0,0,0}, 5'b00001};
    tv[3] = '{'{0,2,0,2}, '{0,3,0,7}, '{0,5,0,9}, 4'b0000, 4'b0000, 4'b0000, -1, -1, 4,
              '{1,3,1,3,0}, '{15,63,15,63,0}, 5'b00000};
    tv[4] = '{'{1,2,0,2}, '{11,3,0,7}, '{10,5,0,9}, 4'b0000, 4'b0000, 4'b0001, 5, -1, 5,
              '{1,3,0,1,3}, '{15,63,110,15,63}, 5'b00000};
    tv[5] = '{'{0,1,0,1}, '{0,1,0,5}, '{0,2,0,5}, 4'b0000, 4'b0000, 4'b0010, 15, 12, 1,
              '{1,0,0,0,0}, '{2,0,0,0,0}, 5'b00000};
    repeat (2) @(negedge clk);
    #1;
    chk("power-on busy", busy, 0);
    chk("power-on mul_rst", mul_rst, 1);
    chk("power-on rsp_valid", rsp_valid, 0);
    chk("power-on rsp_product", rsp_product, 0);
    chk("power-on mul_multiplicand", mul_multiplicand, 0);
    rst = 1'b1;
    for (int r = 0; r < 6; r++) begin
      do_reset();
      load_vec(tv[r]);
      run($sformatf("vec%0d", r));
      chk($sformatf("vec%0d served count", r), sv_g.size(), tv[r].n);
      for (int k = 0; k < tv[r].n && k < sv_g.size(); k++) begin
        chk($sformatf("vec%0d order[%0d]", r, k), sv_g[k], tv[r].ord[k]);
        chk($sformatf("vec%0d product[%0d]", r, k), sv_p[k], tv[r].prod[k]);
        chk($sformatf("vec%0d taint[%0d]", r, k), sv_t[k], tv[r].tnt[k]);
      end
    end
    do_reset();
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < NR; i++) begin
        cnt_left[i] = $urandom_range(0, 2);
        a_op[i] = NB'($urandom);
        b_op[i] = NB'($urandom);
        ta[i] = 1'($urandom_range(0, 1));
        tb[i] = 1'($urandom_range(0, 1));
      end
      if (left() == 0) cnt_left[$urandom_range(0, NR - 1)] = 1;
      late_mask = NR'($urandom_range(0, 15));
      late_at = $urandom_range(0, 50);
      rst_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 70)) : -1;
      run($sformatf("rnd%0d", r));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
